// File: rtl/avr_irq_pkg.sv
// avr_irq_pkg: shared arbiter state type, default sizes and named vector numbers
package avr_irq_pkg;
  localparam int IRQ_NUM_VEC = 45;
  localparam int IRQ_VEC_W   = 6;
  typedef enum logic [1:0] {IDLE, PEND, ACK} irq_state_t;
  localparam logic [IRQ_VEC_W-1:0] VEC_INT0   = 6'd1;
  localparam logic [IRQ_VEC_W-1:0] VEC_INT1   = 6'd2;
  localparam logic [IRQ_VEC_W-1:0] VEC_PCINT0 = 6'd3;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder
module irq_prio_enc #(
  parameter int N = 44,
  parameter int W = 6
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  // scan from the top so the lowest set bit is the last to overwrite idx
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/avr_irq_arbiter.sv
// avr_irq_arbiter: fixed-priority IRQ arbiter with RETI gap; optional wake output under IRQ_ARB_WAKE_EN
module avr_irq_arbiter
  import avr_irq_pkg::*;
#(
  parameter int NUM_VEC = IRQ_NUM_VEC,
  parameter int VEC_W   = IRQ_VEC_W
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [NUM_VEC-2:0] irq_lines,
  input  logic               sreg_i,
  input  logic               instr_end,
  input  logic               reti,
  input  logic               irq_taken,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  output logic               irqack,
  output logic [VEC_W-1:0]   irqack_addr
`ifdef IRQ_ARB_WAKE_EN
  ,
  output logic               wake
`endif
);
  irq_state_t state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d, win_idx;
  logic gap_q, gap_d, win_valid;
  logic [NUM_VEC-1:0] lines_v;

  irq_prio_enc #(.N(NUM_VEC - 1), .W(VEC_W)) u_enc (
    .req   (irq_lines),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign lines_v = {irq_lines, 1'b0};

  // next state: RETI gap tracking plus IDLE/PEND/ACK sequencing
  always_comb begin
    gap_d   = reti | (gap_q & ~instr_end);
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: if (sreg_i && !gap_q && !reti && win_valid) begin
        state_d = PEND;
        vec_d   = win_idx + VEC_W'(1);
      end
      PEND: state_d = irq_taken ? ACK : (!lines_v[vec_q] || !sreg_i) ? IDLE : PEND;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset aborts any pending request or ack
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      gap_q   <= gap_d;
    end
  end

  assign irq_req     = state_q == PEND;
  assign irq_vector  = irq_req ? vec_q : '0;
  assign irqack      = state_q == ACK;
  assign irqack_addr = irqack ? vec_q : '0;

`ifdef IRQ_ARB_WAKE_EN
  logic wake_q, wake_d;
  assign wake_d = |irq_lines;
  // any raw request wakes the core, regardless of enable, gap or state
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) wake_q <= 1'b0;
    else         wake_q <= wake_d;
  end
  assign wake = wake_q;
`endif
endmodule

// File: doc/avr_irq_arbiter.md
# avr_irq_arbiter

Interrupt arbiter between the peripheral IRQ sources (external/pin-change interrupts, timers, USARTs, …) and the AVR core. It picks the highest-priority pending request, holds a stable vector to the core's interrupt-entry sequencer, and returns the one-cycle `irqack`/`irqack_addr` pulse that peripherals use to auto-clear their flags. It also enforces the AVR rule that one instruction executes after RETI before the next interrupt is taken.

## Interface
- `NUM_VEC`, 45: number of vectors including reset (vector 0); valid IRQ vectors are 1..NUM_VEC-1.
- `VEC_W`, 6: width of vector/ack address (must satisfy 2^VEC_W ≥ NUM_VEC).

- `cp2`  in  1  core clock; all state on rising edge.
- `ireset`  in  1  reset, asynchronous, active-low.
- `irq_lines`  in  NUM_VEC-1  level requests; bit k-1 = vector k (already flag&enable in peripheral).
- `sreg_i`  in  1  global interrupt enable (SREG.I).
- `instr_end`  in  1  pulse: core completed an instruction.
- `reti`  in  1  pulse: core executed RETI.
- `irq_taken`  in  1  pulse: core commits to vectoring `irq_vector`.
- `irq_req`  out  1  request to core.
- `irq_vector`  out  VEC_W  vector number presented with `irq_req`.
- `irqack`  out  1  one-cycle acknowledge to peripherals.
- `irqack_addr`  out  VEC_W  vector being acknowledged.
- `wake`  out  1  only with `IRQ_ARB_WAKE_EN` (see Configuration).

## Operation
- Priority: lowest vector number wins (vector 1 highest), fixed.
- `gap` flag: set by `reti`, cleared by the first `instr_end` strictly after the set cycle; `reti` and `instr_end` in the same cycle → `gap`=1.
- FSM, 3 states:
  - IDLE: if `sreg_i`=1, `gap`=0, any `irq_lines` bit set → latch winner into `vec_q`, go PEND.
  - PEND: `irq_req`=1, `irq_vector`=`vec_q`. If `irq_taken` → ACK. Else if `irq_lines[vec_q-1]`=0 or `sreg_i`=0 → withdraw, IDLE. `irq_taken` beats simultaneous withdrawal. A higher-priority line arriving in PEND does not replace `vec_q`.
  - ACK: `irqack`=1, `irqack_addr`=`vec_q` for exactly one cycle, then IDLE.
- Nesting is not tracked: core clears SREG.I on entry; if ISR executes SEI, IDLE re-arbitrates normally.
- `irq_taken` outside PEND is ignored.
- Reset values: state IDLE, `vec_q`=0, `gap`=0, `irq_req`=0, `irq_vector`=0, `irqack`=0, `irqack_addr`=0, `wake`=0. Reset mid-PEND/ACK aborts with no ack pulse.
- Outputs `irq_vector`/`irqack_addr` are 0 whenever `irq_req`/`irqack` are 0.

## Timing
- Line high in cycle N (IDLE, conditions met) → `irq_req` high in N+1.
- `irq_taken` in cycle M (PEND) → `irqack` high in M+1 only; back in IDLE at M+2, earliest new `irq_req` at M+3.
- `reti` in cycle R, `instr_end` in R+k (k≥1) → `gap` clear at R+k+1; arbitration may latch that cycle.
- All outputs registered; no combinational input→output path.

## Configuration
- `IRQ_ARB_WAKE_EN` defined: `wake` port present; registered OR of all `irq_lines`, independent of `sreg_i`, `gap`, and state; one-cycle latency; feeds the sleep controller.
- Undefined: `wake` port and its logic absent; all other behaviour identical.

## Structure
- Shared package `avr_irq_pkg`: `irq_state_t` enum (IDLE, PEND, ACK), default `NUM_VEC`/`VEC_W` constants, named vector constants (e.g. `VEC_INT0`=1, `VEC_INT1`=2, `VEC_PCINT0`=3).
- One sub-module `irq_prio_enc`: combinational lowest-index priority encoder, `NUM_VEC-1` bits → `VEC_W`-bit index + `valid`.

## Test plan
- Single source: `sreg_i`=1, set bit 0 (vector 1); pulse `irq_taken` two cycles later → `irq_req`=1 with `irq_vector`=1 one cycle after the line; `irqack`=1, `irqack_addr`=1 for exactly one cycle after `irq_taken`.
- Priority: bits 2 and 0 rise together → vector 1 served first; after ack and bit 0 cleared, vector 3 requested.
- Withdraw: in PEND, drop the line (or drop `sreg_i`) without `irq_taken` → `irq_req` falls next cycle, no `irqack`; same-cycle drop + `irq_taken` → `irqack` still issued.
- RETI gap: line held high, `reti` in cycle 10, `instr_end` in 13 → no `irq_req` before cycle 15; `irq_req` at 15.
- Reset mid-PEND: assert `ireset`=0 while `irq_req`=1 → all outputs 0 immediately; no `irqack` after release.
- With `IRQ_ARB_WAKE_EN`: `sreg_i`=0, bit 5 high → `wake`=1 next cycle, `irq_req` stays 0.
